// File: rtl/conv2_frame_sequencer.sv
// Frame sequencer in front of conv2: skid FIFO between the max-pool stream and conv2,
// pixel/result counting per frame, frame_done pulse and sticky fault detection.
module conv2_frame_sequencer #(
    parameter int DATA_W     = 12,
    parameter int IMG_W      = 12,
    parameter int IMG_H      = 12,
    parameter int K          = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_s_valid,
    input  logic [DATA_W-1:0] i_s_data1,
    input  logic [DATA_W-1:0] i_s_data2,
    input  logic [DATA_W-1:0] i_s_data3,
    output logic              o_s_ready,
    output logic              o_c_valid,
    output logic [DATA_W-1:0] o_c_data1,
    output logic [DATA_W-1:0] o_c_data2,
    output logic [DATA_W-1:0] o_c_data3,
    input  logic              i_c_ready,
    input  logic              i_c_busy,
    input  logic              i_c_vout,
    output logic              o_frame_done,
    output logic              o_err,
    output logic [7:0]        o_in_cnt,
    output logic [6:0]        o_out_cnt,
    output logic [1:0]        o_state
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NOUT = (IMG_W - K + 1) * (IMG_H - K + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TW   = $clog2(TIMEOUT + 1);

    // state  | meaning
    // IDLE   | waiting for start
    // STREAM | accepting pixels and feeding conv2
    // DRAIN  | all pixels delivered, waiting for remaining results or timeout
    // DONE   | one-cycle frame_done pulse
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3*DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_occ;
    logic [7:0]              r_push_cnt;
    logic [7:0]              r_in_cnt;
    logic [6:0]              r_out_cnt;
    logic [TW-1:0]           r_idle_cnt;
    logic                    r_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_last_pop;
    logic w_vout_ok;
    logic w_vout_err;
    logic w_drain_done;
    logic w_timeout;
    logic w_abort;
    logic w_frame_start;

    assign w_full    = (r_occ == (AW+1)'(FIFO_DEPTH));
    assign w_empty   = (r_occ == '0);
    assign o_s_ready = (r_state == STREAM) && !w_full && (r_push_cnt < 8'(NPIX));
    assign o_c_valid = (r_state == STREAM) && !w_empty;
    assign w_push    = o_s_ready && i_s_valid;
    assign w_pop     = o_c_valid && i_c_ready;
    assign w_last_pop = w_pop && (r_in_cnt == 8'(NPIX - 1));

    assign w_vout_ok    = i_c_vout && ((r_state == STREAM) || (r_state == DRAIN))
                          && (r_out_cnt != 7'(NOUT));
    assign w_vout_err   = i_c_vout && !w_vout_ok;
    assign w_drain_done = (r_out_cnt == 7'(NOUT)) && !i_c_busy;
    // Abort on the TIMEOUT-th consecutive DRAIN cycle without a result
    assign w_timeout    = (r_state == DRAIN) && !i_c_vout && (r_idle_cnt == TW'(TIMEOUT - 1));
    assign w_abort      = w_timeout && !w_drain_done;

    assign {o_c_data1, o_c_data2, o_c_data3} = r_mem[r_rd_ptr];
    assign o_frame_done = (r_state == DONE);
    assign o_err        = r_err;
    assign o_in_cnt     = r_in_cnt;
    assign o_out_cnt    = r_out_cnt;
    assign o_state      = r_state;

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt   = STREAM;
                    w_frame_start = 1'b1;
                end
            end
            STREAM: if (w_last_pop) w_state_nxt = DRAIN;
            DRAIN:  if (w_drain_done || w_timeout) w_state_nxt = DONE;
            DONE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_push_cnt <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_idle_cnt <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_frame_start) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_occ      <= '0;
                r_push_cnt <= '0;
                r_in_cnt   <= '0;
                r_out_cnt  <= '0;
                r_idle_cnt <= '0;
                r_err      <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= {i_s_data1, i_s_data2, i_s_data3};
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                    r_push_cnt      <= r_push_cnt + 8'd1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_in_cnt <= r_in_cnt + 8'd1;
                end
                if (w_push && !w_pop) begin
                    r_occ <= r_occ + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_occ <= r_occ - 1'b1;
                end
                if (w_vout_ok) r_out_cnt <= r_out_cnt + 7'd1;
                if (r_state == DRAIN) r_idle_cnt <= i_c_vout ? '0 : r_idle_cnt + 1'b1;
                if (w_abort) r_err <= 1'b1;
            end
            if (w_vout_err) r_err <= 1'b1;
        end
    end

endmodule
